// File: rtl/updown_mod_counter_if.sv
// rtl/updown_mod_counter_if.sv - control/status bundle for updown_mod_counter (BCD ports under UPDOWN_MOD_COUNTER_BCD_EN)
interface updown_mod_counter_if #(
  parameter int WIDTH = 5
);
  logic             p_c;
  logic             u_d;
  logic             ci;
  logic             load;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;
  logic             co;
  logic             at_limit;
`ifdef UPDOWN_MOD_COUNTER_BCD_EN
  logic [3:0]       bcd_tens;
  logic [3:0]       bcd_ones;

  modport master (output p_c, u_d, ci, load, d,
                  input  q, co, at_limit, bcd_tens, bcd_ones);
  modport slave  (input  p_c, u_d, ci, load, d,
                  output q, co, at_limit, bcd_tens, bcd_ones);
`else
  modport master (output p_c, u_d, ci, load, d,
                  input  q, co, at_limit);
  modport slave  (input  p_c, u_d, ci, load, d,
                  output q, co, at_limit);
`endif
endinterface

// File: rtl/updown_mod_counter.sv
// rtl/updown_mod_counter.sv - parametrised up/down modulo counter; optional BCD digits via UPDOWN_MOD_COUNTER_BCD_EN
module updown_mod_counter #(
  parameter int WIDTH    = 5,
  parameter int MODULO   = 20,
  parameter int INIT     = 0,
  parameter int SAT_MODE = 0
) (
  input logic                clk,
  input logic                rst,
  updown_mod_counter_if.slave bus
);
  localparam logic [WIDTH-1:0] MAX_Q  = WIDTH'(MODULO - 1);
  localparam logic [WIDTH-1:0] INIT_Q = WIDTH'(INIT);
  localparam logic [WIDTH:0]   MOD_W  = (WIDTH+1)'(MODULO);

  if (MODULO < 2 || MODULO > (2**WIDTH)) begin : g_bad_modulo
    $error("updown_mod_counter: MODULO out of range for WIDTH");
  end
  if (INIT < 0 || INIT >= MODULO) begin : g_bad_init
    $error("updown_mod_counter: INIT must be below MODULO");
  end

  logic [WIDTH-1:0] q_next;
  logic             at_top;
  logic             at_bottom;
  logic             counting;

  assign at_top    = (bus.q == MAX_Q);
  assign at_bottom = (bus.q == '0);
  assign counting  = bus.ci & ~bus.p_c;

  // Carry fires even when saturating so a chained upper stage still advances.
  assign bus.co = counting & ~bus.load & ~rst & (bus.u_d ? at_top : at_bottom);

  always_comb begin
    q_next = bus.q;
    if (bus.load) begin
      q_next = ({1'b0, bus.d} < MOD_W) ? bus.d : MAX_Q;
    end else if (counting) begin
      if (bus.u_d) begin
        if (at_top) q_next = (SAT_MODE != 0) ? MAX_Q : '0;
        else        q_next = bus.q + WIDTH'(1);
      end else begin
        if (at_bottom) q_next = (SAT_MODE != 0) ? '0 : MAX_Q;
        else           q_next = bus.q - WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.q        <= INIT_Q;
      bus.at_limit <= 1'b0;
    end else begin
      bus.q        <= q_next;
      bus.at_limit <= bus.u_d ? (q_next == MAX_Q) : (q_next == '0);
    end
  end

`ifdef UPDOWN_MOD_COUNTER_BCD_EN
  if (MODULO > 100) begin : g_bad_bcd
    $error("updown_mod_counter: BCD outputs need MODULO <= 100");
  end

  logic [31:0] q_next_w;
  assign q_next_w = 32'(q_next);

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.bcd_tens <= 4'(INIT / 10);
      bus.bcd_ones <= 4'(INIT % 10);
    end else begin
      bus.bcd_tens <= 4'(q_next_w / 32'd10);
      bus.bcd_ones <= 4'(q_next_w % 32'd10);
    end
  end
`endif
endmodule

// File: doc/updown_mod_counter.md
Name: updown_mod_counter

Overview:
- Parametrised up/down modulo counter. Successor to the fixed 5-bit mod-20 pause/direction counter.
- Adds generic width and modulus, a synchronous parallel load, cascade-in/carry-out for chaining, and selectable wrap or saturate mode.
- Used as the timing/digit building block in the exam-board clock and timer datapaths; instances chain via CI/CO to form multi-digit counters.

Parameters:
- WIDTH, 5, bit width of Q and D; must satisfy 2**WIDTH >= MODULO.
- MODULO, 20, count range 0..MODULO-1; legal values 2..2**WIDTH.
- INIT, 0, value loaded into Q by reset; must be < MODULO.
- SAT_MODE, 0, 0 = wrap at the boundaries, 1 = saturate at the boundaries.

Ports:
- CLK  input  1  sole clock; rising edge.
- RST  input  1  synchronous, active-high reset.
- P_C  input  1  1 = pause, 0 = continue.
- U_D  input  1  1 = count up, 0 = count down.
- CI  input  1  cascade enable; counting occurs only when CI=1. Tie to 1 when standalone.
- LOAD  input  1  synchronous parallel load strobe.
- D  input  WIDTH  load value.
- Q  output  WIDTH  registered count.
- CO  output  1  combinational terminal-count / carry-out to the next stage.
- AT_LIMIT  output  1  registered flag; 1 while Q sits at the boundary for the current direction.

Behaviour:
- Clocking and reset: one clock (CLK). Reset RST is synchronous and active-high; it is sampled only on the CLK rising edge.
- Priority per rising CLK edge: RST > LOAD > pause > count.
- RST=1: Q <= INIT, AT_LIMIT <= 0. Reset mid-count discards the count; no pending state survives.
- LOAD=1 (RST=0): Q <= D if D < MODULO, else Q <= MODULO-1 (clamp). LOAD acts regardless of P_C and CI.
- Pause: P_C=1 or CI=0 -> Q holds.
- Count up (U_D=1): if Q == MODULO-1, Q <= 0 when SAT_MODE=0, or Q holds at MODULO-1 when SAT_MODE=1; otherwise Q <= Q+1.
- Count down (U_D=0): if Q == 0, Q <= MODULO-1 when SAT_MODE=0, or Q holds at 0 when SAT_MODE=1; otherwise Q <= Q-1.
- Latency: one cycle from the qualifying edge to the new Q. U_D may change on any cycle and takes effect at the next edge with no dead cycle.
- CO = CI & ~P_C & ~LOAD & ~RST & (U_D ? Q==MODULO-1 : Q==0).
  - Purely combinational; asserts in the cycle before the wrap edge.
  - CO asserts in SAT_MODE=1 as well, so a chained upper stage still advances.
- AT_LIMIT: registered each edge from the next Q and the current U_D. Equals 1 when next Q == MODULO-1 (U_D=1) or next Q == 0 (U_D=0).
- Width arithmetic: comparisons and increment/decrement are done at WIDTH bits. The Q+1 result never exceeds MODULO-1, so no overflow. MODULO == 2**WIDTH is legal and wraps naturally.
- Q never takes a value >= MODULO under any input sequence.
- Simultaneous LOAD and count: LOAD wins; CO=0 that cycle.

Optional Feature:
- Macro UPDOWN_MOD_COUNTER_BCD_EN.
- Defined:
  - Adds outputs BCD_TENS[3:0] and BCD_ONES[3:0], registered from the next Q so they are cycle-aligned with Q.
  - Reset values are the digits of INIT.
  - Legal only for MODULO <= 100; elaboration-time error otherwise.
- Undefined: ports absent, no divider logic; counter behaviour is identical.

Test Plan:
- Defaults, RST=1 for 2 cycles, then P_C=0, U_D=1, CI=1 for 21 cycles -> Q steps 0..19 then 0. CO=1 only while Q=19. AT_LIMIT=1 only while Q=19.
- Defaults, Q=0, U_D=0 for 3 cycles -> Q = 19, 18, 17. CO=1 in the Q=0 cycle.
- Defaults, Q=7, P_C=1 for 5 cycles (or CI=0) -> Q stays 7, CO=0. Release -> Q=8 next edge.
- LOAD=1 with D=25 -> Q=19. LOAD=1 with D=5 and P_C=1 -> Q=5. LOAD and RST together -> Q=INIT.
- SAT_MODE=1, WIDTH=4, MODULO=10: count up from 8 -> 9, 9, 9 with CO=1 each held cycle. Count down from 1 -> 0, 0.
- BCD macro defined, MODULO=60: load 47 -> BCD_TENS=4 and BCD_ONES=7 on the same edge as Q=47. Count up from 59 -> digits 0, 0. RST at Q=33 -> Q=0 and digits 0 next edge.
